// File: rtl/alu_ctrl_stage.sv
// Execute-stage ALU-control generator: opcode/funct decode into a 2-entry ready/valid skid buffer.
// Optional macro ALU_CTRL_ILLEGAL_EN: unsupported encodings raise the illegal flag on their entry.
module alu_ctrl_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] alu_control,
  output logic       illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] head_q, head_d;
  logic [3:0] tail_q, tail_d;
  logic [3:0] entry;
  logic [2:0] ctl;
  logic       unsup;
  logic       accept;
  logic       pop;

  always_comb begin
    ctl   = '0;
    unsup = 1'b0;
    case (op)
      7'b0000011, 7'b0100011: ctl = 3'b000;
      7'b1100011:             ctl = 3'b001;
      7'b0110011, 7'b0010011: begin
        case (funct3)
          3'b000:  ctl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ctl = 3'b101;
          3'b110:  ctl = 3'b011;
          3'b111:  ctl = 3'b010;
          default: unsup = 1'b1;
        endcase
      end
      default: unsup = 1'b1;
    endcase
`ifdef ALU_CTRL_ILLEGAL_EN
    entry = unsup ? 4'b0001 : {ctl, 1'b0};
`else
    entry = {(unsup ? 3'b000 : ctl), 1'b0};
`endif
  end

  // Ready depends only on registered state so EX back-pressure never reaches decode combinationally.
  assign in_ready    = (state_q != TWO);
  assign out_valid   = (state_q != EMPTY);
  assign alu_control = head_q[3:1];
  assign illegal     = head_q[0];
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = entry;
          end else if (accept) begin
            tail_d  = entry;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule
